// File: rtl/vector_exec_controller.sv
// Vector execute controller: issues one instruction to the VFU, waits for completion, then merges the
// result with the old vd under v0 mask / vl (mask and tail undisturbed) and emits one register-file write.
module vector_exec_controller #(
  parameter int DATA_LEN    = 32,
  parameter int VECTOR_SIZE = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [4:0]                      issue_vd,
  input  logic [2:0]                      issue_eew,
  input  logic                            issue_vm,
  input  logic [DATA_LEN-1:0]             issue_vl,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] issue_old_vd,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] issue_v0,
  output logic                            vfu_execute,
  input  logic [1:0]                      vfu_status,
  input  logic [VECTOR_SIZE*DATA_LEN-1:0] vfu_result,
  input  logic                            vfu_is_mask,
  output logic                            wb_en,
  output logic [4:0]                      wb_idx,
  output logic [VECTOR_SIZE*DATA_LEN-1:0] wb_data,
  output logic                            done,
  output logic                            err_timeout,
  output logic                            busy
);

  localparam int VLEN = VECTOR_SIZE * DATA_LEN;
  localparam int IW   = $clog2(VLEN + 1);
  localparam int AW   = $clog2(VLEN);
  localparam int CW   = $clog2(TIMEOUT + 1);

  // Status encoding shared with the VFU: NOP=0, WORKING=1, FINISHED=2.
  localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WB} state_t;

  state_t              state, state_nx;
  logic [4:0]          vd_q;
  logic [2:0]          eew_q;
  logic                vm_q;
  logic [DATA_LEN-1:0] vl_q;
  logic [VLEN-1:0]     old_q, v0_q;
  logic [CW-1:0]       wdog;
  logic [VLEN-1:0]     sel, merged;
  logic [IW-1:0]       vlmax, vl_eff, elem;

  wire vfu_finished = (vfu_status == VEC_ALU_FINISHED);

  // Element width is 8 << eew bits, so VLMAX = (VLEN/8) >> eew.
  always_comb begin
    vlmax  = IW'(VLEN / 8) >> eew_q;
    vl_eff = (vl_q < DATA_LEN'(vlmax)) ? IW'(vl_q) : vlmax;
    sel    = '0;
    elem   = '0;
    for (int b = 0; b < VLEN; b++) begin
      elem   = vfu_is_mask ? IW'(b) : IW'(b >> (3 + eew_q));
      sel[b] = (elem < vl_eff) && (vm_q || v0_q[elem[AW-1:0]]);
    end
    merged = (vfu_result & sel) | (old_q & ~sel);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      vd_q    <= '0;
      eew_q   <= '0;
      vm_q    <= 1'b0;
      vl_q    <= '0;
      old_q   <= '0;
      v0_q    <= '0;
      wdog    <= '0;
      wb_data <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      if (state == S_IDLE && issue_valid) begin
        vd_q  <= issue_vd;
        eew_q <= issue_eew;
        vm_q  <= issue_vm;
        vl_q  <= issue_vl;
        old_q <= issue_old_vd;
        v0_q  <= issue_v0;
      end
      if (state == S_LAUNCH) wdog <= '0;
      if (state == S_WAIT) begin
        if (vfu_finished) wb_data <= merged;
        else              wdog    <= wdog + 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    err_timeout = 1'b0;
    case (state)
      S_IDLE:   if (issue_valid) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (vfu_finished) begin
          state_nx = S_WB;
        end else if (wdog == CW'(TIMEOUT - 1)) begin
          state_nx    = S_IDLE;
          err_timeout = rdy_in;
        end
      end
      S_WB:     state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Ready is withheld while frozen so a handshake can never be silently dropped.
  assign issue_ready = rdy_in && (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign vfu_execute = rdy_in && (state == S_LAUNCH);
  assign done        = rdy_in && (state == S_WB);
  assign wb_en       = done && (vl_q != '0);
  assign wb_idx      = vd_q;

endmodule

// File: tb/tb_vector_exec_controller.sv
// Randomized scoreboard bench for vector_exec_controller with a behavioural VFU and an element-level merge model.
module tb_vector_exec_controller;

  localparam int DATA_LEN    = 32;
  localparam int VECTOR_SIZE = 8;
  localparam int VLEN        = VECTOR_SIZE * DATA_LEN;
  localparam int TIMEOUT     = 4;

  localparam logic [1:0] ST_NOP = 2'd0, ST_WORKING = 2'd1, ST_FINISHED = 2'd2;
  localparam logic [2:0] ONE_BYTE = 3'd0, FOUR_BYTE = 3'd2;

  typedef logic [VLEN-1:0] vec_t;
  typedef enum {EV_WB, EV_DONE_ONLY, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [4:0] idx;
    vec_t       data;
    int         cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst, rdy_in, issue_valid, issue_ready, issue_vm;
  logic [4:0]          issue_vd, wb_idx;
  logic [2:0]          issue_eew;
  logic [DATA_LEN-1:0] issue_vl;
  vec_t                issue_old_vd, issue_v0, vfu_result, wb_data;
  logic                vfu_execute, vfu_is_mask, wb_en, done, err_timeout, busy;
  logic [1:0]          vfu_status;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0;
  int   vfu_work_next = 0, vfu_cnt = 0;
  bit   vfu_pending = 0, chk_ready = 0;

  vector_exec_controller #(.DATA_LEN(DATA_LEN), .VECTOR_SIZE(VECTOR_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_vd(issue_vd), .issue_eew(issue_eew),
    .issue_vm(issue_vm), .issue_vl(issue_vl), .issue_old_vd(issue_old_vd), .issue_v0(issue_v0),
    .vfu_execute(vfu_execute), .vfu_status(vfu_status), .vfu_result(vfu_result), .vfu_is_mask(vfu_is_mask),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .done(done), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference merge: walk elements of width 8<<eew; active elements take the result, others keep old vd.
  function automatic vec_t ref_merge(input vec_t old, input vec_t v0, input vec_t res, input logic [2:0] eew,
                                     input logic vm, input logic [31:0] vl, input logic is_mask);
    int   ew     = 8 << eew;
    int   vlmax  = VLEN / ew;
    int   vl_eff = (vl < vlmax) ? int'(vl) : vlmax;
    vec_t d      = old;
    for (int i = 0; i < vl_eff; i++) begin
      if (vm || v0[i]) begin
        if (is_mask) d[i] = res[i];
        else for (int j = 0; j < ew; j++) d[i*ew + j] = res[i*ew + j];
      end
    end
    return d;
  endfunction

  // Behavioural VFU: a launch seen in one cycle yields `working` WORKING cycles, then one FINISHED cycle.
  initial begin
    vfu_status = ST_NOP;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        vfu_status  = ST_NOP;
        vfu_pending = 0;
      end else begin
        if (vfu_status == ST_FINISHED) vfu_status = ST_NOP;
        if (vfu_pending) begin
          if (vfu_cnt == 0) begin
            vfu_status  = ST_FINISHED;
            vfu_pending = 0;
          end else begin
            vfu_status = ST_WORKING;
            vfu_cnt--;
          end
        end
        if (vfu_execute) begin
          vfu_pending = 1;
          vfu_cnt     = vfu_work_next;
        end
      end
    end
  end

  // Monitor: every completion/abort pulse is matched against the oldest expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (chk_ready) begin
        check("ready_after_timeout", vec_t'(issue_ready), vec_t'(1'b1));
        chk_ready = 0;
      end
      if (!rst && (done || wb_en || err_timeout)) begin
        if (sb.size() == 0) begin
          check("unexpected_event", vec_t'(1'b1), vec_t'(1'b0));
        end else begin
          e = sb.pop_front();
          check("event_cycle", vec_t'(cyc), vec_t'(e.cyc));
          check("done", vec_t'(done), vec_t'(e.kind != EV_TIMEOUT));
          check("err_timeout", vec_t'(err_timeout), vec_t'(e.kind == EV_TIMEOUT));
          check("wb_en", vec_t'(wb_en), vec_t'(e.kind == EV_WB));
          if (e.kind == EV_WB) begin
            check("wb_idx", vec_t'(wb_idx), vec_t'(e.idx));
            check("wb_data", wb_data, e.data);
          end
          if (err_timeout) chk_ready = 1;
        end
      end
    end
  end

  task automatic issue_op(input logic [4:0] vd, input logic [2:0] eew, input logic vm, input logic [31:0] vl,
                          input vec_t old, input vec_t v0, input vec_t res, input logic is_mask,
                          input int working, input int freeze, input bit push);
    exp_t e;
    int   budget = 0;
    @(negedge clk);
    while (!issue_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (!issue_ready) begin
      check("issue_ready_wait", vec_t'(issue_ready), vec_t'(1'b1));
      return;
    end
    issue_valid   = 1'b1;
    issue_vd      = vd;
    issue_eew     = eew;
    issue_vm      = vm;
    issue_vl      = vl;
    issue_old_vd  = old;
    issue_v0      = v0;
    vfu_result    = res;
    vfu_is_mask   = is_mask;
    vfu_work_next = working;
    e.idx  = vd;
    e.data = ref_merge(old, v0, res, eew, vm, vl, is_mask);
    if (working >= TIMEOUT) begin
      e.kind = EV_TIMEOUT;
      e.cyc  = cyc + 1 + TIMEOUT + freeze;
    end else begin
      e.kind = (vl == 0) ? EV_DONE_ONLY : EV_WB;
      e.cyc  = cyc + 3 + working + freeze;
    end
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Busy now: scrambled issue fields must not leak into the operation.
    issue_valid  = 1'($urandom);
    issue_vd     = 5'($urandom);
    issue_eew    = 3'($urandom);
    issue_vm     = 1'($urandom);
    issue_vl     = $urandom;
    issue_old_vd = rand_vec();
    issue_v0     = rand_vec();
    if (freeze > 0) begin
      rdy_in = 1'b0;
      #1 check("exec_frozen", vec_t'(vfu_execute), vec_t'(1'b0));
      @(negedge clk);
      issue_valid = 1'b0;
      repeat (freeze - 1) @(negedge clk);
      rdy_in = 1'b1;
      #1 check("exec_resumed", vec_t'(vfu_execute), vec_t'(1'b1));
    end else begin
      @(negedge clk);
      issue_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_issue_ready"}, vec_t'(issue_ready), vec_t'(1'b1));
    check({tag, "_busy"}, vec_t'(busy), vec_t'(1'b0));
    check({tag, "_vfu_execute"}, vec_t'(vfu_execute), vec_t'(1'b0));
    check({tag, "_wb_en"}, vec_t'(wb_en), vec_t'(1'b0));
    check({tag, "_done"}, vec_t'(done), vec_t'(1'b0));
    check({tag, "_err_timeout"}, vec_t'(err_timeout), vec_t'(1'b0));
    check({tag, "_wb_idx"}, vec_t'(wb_idx), vec_t'(5'd0));
    check({tag, "_wb_data"}, wb_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int   drain = 0;
    vec_t ones  = '1;
    rst = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; issue_vd = '0; issue_eew = '0; issue_vm = 1'b0;
    issue_vl = '0; issue_old_vd = '0; issue_v0 = '0; vfu_result = '0; vfu_is_mask = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;

    issue_op(5'd5, FOUR_BYTE, 1'b1, 32'd8, rand_vec(), rand_vec(), {8{32'h11111111}}, 1'b0, 2, 0, 1);
    issue_op(5'd9, FOUR_BYTE, 1'b0, 32'd4, {8{32'hAAAAAAAA}}, vec_t'(8'h05), {8{32'h1}}, 1'b0, 0, 0, 1);
    issue_op(5'd3, ONE_BYTE, 1'b1, 32'd3, ones, rand_vec(), {rand_vec() >> 3, 3'b101}, 1'b1, 1, 0, 1);
    issue_op(5'd7, FOUR_BYTE, 1'b1, 32'd0, rand_vec(), rand_vec(), rand_vec(), 1'b0, 0, 0, 1);
    issue_op(5'd11, FOUR_BYTE, 1'b1, 32'd8, rand_vec(), rand_vec(), rand_vec(), 1'b0, 60, 0, 1);
    issue_op(5'd13, ONE_BYTE, 1'b0, 32'd20, rand_vec(), rand_vec(), rand_vec(), 1'b0, 1, 3, 1);

    // Reset mid-WAIT: the aborted operation must produce no event at all.
    issue_op(5'd17, FOUR_BYTE, 1'b1, 32'd8, rand_vec(), rand_vec(), rand_vec(), 1'b0, 50, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("rst_in_wait");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int          sel_vl = $urandom_range(0, 9);
      logic [31:0] vl     = (sel_vl == 0) ? 32'd0 : (sel_vl == 1) ? $urandom : 32'($urandom_range(1, 40));
      issue_op(5'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), vl, rand_vec(), rand_vec(), rand_vec(),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 5), 0, 1);
    end

    while (sb.size() != 0 && drain < 200) begin
      @(negedge clk);
      drain++;
    end
    check("scoreboard_drain", vec_t'(sb.size()), '0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
